mdu_hilo: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in EX beside the ALU, fed by the same R-type funct field the ALU decoder consumes.
- Executes mult/multu/div/divu over a fixed 33-cycle sequence and services mthi/mtlo writes.
- HI/LO are exported for mfhi/mflo. A stall request is raised while a new MD op would collide with a running one.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_div_step.sv | 33 +++
 rtl/mdu_hilo.sv | 176 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and types for the multiply/divide unit.
//   MDU_WIDTH     default operand width
//   FUNCT_*       R-type function codes handled by the unit
//   mdu_state_t   sequencer states (IDLE -> RUN -> FIX -> IDLE)
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem_i      partial remainder (always < divisor)
//   dvd_bit_i  next dividend bit, MSB first
//   quo_i      quotient bits developed so far
//   divisor_i  divisor magnitude
//   rem_o      updated remainder
//   quo_o      quotient shifted left with the new bit in the LSB
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;

    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        trial   = {1'b0, shifted} - {2'b00, divisor_i};
        // No borrow means the divisor fits; both candidate remainders are
        // below the divisor, so the top bit can be dropped safely.
        fits    = ~trial[WIDTH+1];
        rem_o   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO.
//   clk, rst        clock and asynchronous active-high reset
//   md_req, start   MD-class instruction present / issue strobe
//   flush           abort in-flight operation, suppress same-cycle issue
//   funct           R-type function code
//   rs_val, rt_val  operands A and B
//   hi, lo          HI/LO registers (no bypass)
//   busy            iteration in progress (registered)
//   done            one-cycle pulse after mult/div wrote HI/LO (registered)
//   stall           busy & md_req (combinational)
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_req,
    input  logic             start,
    input  logic             flush,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_t         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;          // operand magnitudes
    logic [2*WIDTH-1:0] acc_q;             // {hi part, lo part} of the result
    logic               is_div_q, sa_q, sb_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    // Decode and issue qualification
    logic is_muldiv, is_unsigned, accept;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;

    always_comb begin
        is_muldiv   = (funct[5:2] == 4'b0110);
        is_unsigned = funct[0];
        accept      = start & md_req & ~busy_q & ~flush & (state_q == IDLE);
        mag_a_d     = (!is_unsigned && rs_val[WIDTH-1]) ? ('0 - rs_val) : rs_val;
        mag_b_d     = (!is_unsigned && rt_val[WIDTH-1]) ? ('0 - rt_val) : rt_val;
    end

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right; the carry becomes the new MSB.
    logic [WIDTH:0]     mul_upper_d;
    logic [2*WIDTH-1:0] mul_acc_d;

    always_comb begin
        mul_upper_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
        mul_acc_d   = {mul_upper_d, acc_q[WIDTH-1:1]};
    end

    // Divide step: remainder in the upper half, quotient in the lower half,
    // dividend bits fed MSB first out of a_q.
    logic [WIDTH-1:0] div_rem_d, div_quo_d;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .dvd_bit_i (a_q[WIDTH-1]),
        .quo_i     (acc_q[WIDTH-1:0]),
        .divisor_i (b_q),
        .rem_o     (div_rem_d),
        .quo_o     (div_quo_d)
    );

    // Sign correction applied on the FIX edge
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   fix_hi_d, fix_lo_d, rem_s_d;

    always_comb begin
        prod_d  = (sa_q ^ sb_q) ? ('0 - acc_q) : acc_q;
        // Remainder follows the dividend sign; for divide-by-zero the
        // remainder equals |rs_val|, so this also restores the raw rs_val.
        rem_s_d = sa_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
            fix_lo_d = prod_d[WIDTH-1:0];
        end else if (dz_q) begin
            fix_hi_d = rem_s_d;
            fix_lo_d = '1;
        end else begin
            fix_hi_d = rem_s_d;
            fix_lo_d = (sa_q ^ sb_q) ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_muldiv) begin
                            a_q      <= mag_a_d;
                            b_q      <= mag_b_d;
                            acc_q    <= '0;
                            is_div_q <= funct[1];
                            sa_q     <= ~is_unsigned & rs_val[WIDTH-1];
                            sb_q     <= ~is_unsigned & rt_val[WIDTH-1];
                            dz_q     <= (rt_val == '0);
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end else if (funct == FUNCT_MTHI) begin
                            hi_q <= rs_val;
                        end else if (funct == FUNCT_MTLO) begin
                            lo_q <= rs_val;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        if (is_div_q) begin
                            acc_q <= {div_rem_d, div_quo_d};
                            a_q   <= a_q << 1;
                        end else begin
                            acc_q <= mul_acc_d;
                            b_q   <= b_q >> 1;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!flush) begin
                        hi_q   <= fix_hi_d;
                        lo_q   <= fix_lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & md_req;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scenario tasks checked against an arithmetic reference model.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        md_req = 1'b0, start = 1'b0, flush = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] hi_m = '0, lo_m = '0;   // model of architectural HI/LO

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .md_req(md_req), .start(start), .flush(flush),
        .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, b,
                                   output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] up;
        longint      sp;
        int          sa, sb;
        rh = '0; rl = '0;
        case (f)
            FUNCT_MULTU: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
            FUNCT_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp; rh = up[63:32]; rl = up[31:0];
            end
            FUNCT_DIVU: begin
                if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
                else begin rl = a / b; rh = a % b; end
            end
            FUNCT_DIV: begin
                if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = 0; end
                else begin sa = a; sb = b; rl = sa / sb; rh = sa % sb; end
            end
            default: ;
        endcase
    endfunction

    // Issue one mult/div, count busy cycles, check done pulse and result.
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, b);
        int n;
        logic [31:0] eh, el;
        ref_md(f, a, b, eh, el);
        @(negedge clk);
        md_req = 1; start = 1; funct = f; rs_val = a; rt_val = b;
        @(negedge clk);
        md_req = 0; start = 0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin n++; @(negedge clk); end
        n_cmp++; if (n !== 33) begin n_err++; $display("FAIL %s busy_cycles got=%0d exp=33", name, n); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s done got=%b exp=1", name, done); end
        n_cmp++; if (hi !== eh || lo !== el) begin
            n_err++; $display("FAIL %s hilo got=%h_%h exp=%h_%h", name, hi, lo, eh, el);
        end
        hi_m = eh; lo_m = el;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done_width got=%b exp=0", name, done); end
        $display("op %s f=%b a=%h b=%h -> hi=%h lo=%h", name, f, a, b, hi, lo);
    endtask

    task automatic test_reset;
        rst = 1; #12;
        n_cmp++; if ({hi, lo, busy, done, stall} !== '0) begin
            n_err++; $display("FAIL reset got hi=%h lo=%h busy=%b done=%b stall=%b exp=0", hi, lo, busy, done, stall);
        end
        @(negedge clk); rst = 0;
        $display("reset checked");
    endtask

    task automatic test_directed;
        run_op("multu_ff_x2", FUNCT_MULTU, 32'hFFFF_FFFF, 32'h2);
        run_op("mult_m3_x7", FUNCT_MULT, -32'sd3, 32'd7);
        run_op("div_m7_2", FUNCT_DIV, -32'sd7, 32'd2);
        run_op("divu_100_0", FUNCT_DIVU, 32'd100, 32'd0);
        run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_neg_by_0", FUNCT_DIV, 32'hFFFF_FF00, 32'd0);
    endtask

    task automatic test_random;
        logic [5:0] fs [4] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 300));
            run_op("rand", fs[$urandom_range(0, 3)], a, b);
        end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        md_req = 1; start = 1; funct = FUNCT_MTHI; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        funct = FUNCT_MTLO; rs_val = 32'h1234_5678;
        hi_m = 32'hDEAD_BEEF;
        n_cmp++; if (hi !== hi_m || lo !== lo_m || busy !== 0 || done !== 0) begin
            n_err++; $display("FAIL mthi got hi=%h lo=%h busy=%b done=%b exp hi=%h lo=%h", hi, lo, busy, done, hi_m, lo_m);
        end
        @(negedge clk);
        funct = FUNCT_MFHI;
        lo_m = 32'h1234_5678;
        n_cmp++; if (hi !== hi_m || lo !== lo_m || busy !== 0) begin
            n_err++; $display("FAIL mtlo got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, hi_m, lo_m);
        end
        @(negedge clk);
        md_req = 0; start = 0;
        n_cmp++; if (hi !== hi_m || lo !== lo_m || busy !== 0) begin
            n_err++; $display("FAIL mfhi_nochange got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, hi_m, lo_m);
        end
        $display("mthi/mtlo hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_flush_on_start;
        @(negedge clk);
        md_req = 1; start = 1; flush = 1; funct = FUNCT_MTHI; rs_val = 32'h0BAD_0BAD;
        @(negedge clk);
        funct = FUNCT_MULT;
        n_cmp++; if (hi !== hi_m || busy !== 0) begin
            n_err++; $display("FAIL flush_mthi got hi=%h busy=%b exp hi=%h busy=0", hi, busy, hi_m);
        end
        @(negedge clk);
        md_req = 0; start = 0; flush = 0;
        n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL flush_mult busy got=%b exp=0", busy); end
        $display("flush with start checked");
    endtask

    task automatic test_flush_mid;
        int dones = 0;
        @(negedge clk);
        md_req = 1; start = 1; funct = FUNCT_MULT; rs_val = 32'd12345; rt_val = 32'd777;
        @(negedge clk);
        md_req = 0; start = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL flush_mid busy got=%b exp=0", busy); end
        repeat (30) begin @(negedge clk); if (done === 1'b1) dones++; end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL flush_mid done_pulses got=%0d exp=0", dones); end
        n_cmp++; if (hi !== hi_m || lo !== lo_m) begin
            n_err++; $display("FAIL flush_mid hilo got=%h_%h exp=%h_%h", hi, lo, hi_m, lo_m);
        end
        $display("flush mid-run checked");
    endtask

    task automatic test_hazard;
        int n, dones;
        logic [31:0] eh, el;
        ref_md(FUNCT_DIVU, 32'hCAFE_1234, 32'd999, eh, el);
        @(negedge clk);
        md_req = 1; start = 1; funct = FUNCT_DIVU; rs_val = 32'hCAFE_1234; rt_val = 32'd999;
        @(negedge clk);
        md_req = 0; start = 0;
        n = 0; dones = 0;
        while (busy === 1'b1 && n < 60) begin
            if (n == 5) begin md_req = 1; start = 1; funct = FUNCT_MTHI; rs_val = 32'h5555_AAAA; end
            if (n == 6) begin
                n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL hazard stall got=%b exp=1", stall); end
            end
            n++; @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL hazard stall_release got=%b exp=0", stall); end
        md_req = 0; start = 0;
        n_cmp++; if (n !== 33 || dones !== 1) begin
            n_err++; $display("FAIL hazard cycles got=%0d dones=%0d exp=33/1", n, dones);
        end
        n_cmp++; if (hi !== eh || lo !== el) begin
            n_err++; $display("FAIL hazard hilo got=%h_%h exp=%h_%h", hi, lo, eh, el);
        end
        hi_m = eh; lo_m = el;
        @(negedge clk);
        n_cmp++; if (hi !== hi_m || busy !== 0) begin
            n_err++; $display("FAIL hazard late_write got hi=%h busy=%b exp hi=%h", hi, busy, hi_m);
        end
        $display("hazard divu hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        md_req = 1; start = 1; funct = FUNCT_MULTU; rs_val = 32'hFFFF_0000; rt_val = 32'hFFFF;
        @(negedge clk);
        md_req = 0; start = 0;
        repeat (19) @(negedge clk);
        #2 rst = 1;
        #1;
        n_cmp++; if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            n_err++; $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b exp=0", hi, lo, busy, done);
        end
        hi_m = 0; lo_m = 0;
        @(negedge clk); rst = 0;
        run_op("multu_6x7", FUNCT_MULTU, 32'd6, 32'd7);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_flush_on_start();
        test_flush_mid();
        test_hazard();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
